// File: rtl/ghost_mover.sv
`default_nettype none
// ============================================================================
// Module : ghost_mover
// Probes the four maze neighbours of one ghost and executes its moves.
// Rev    : 1.0  initial release
// ============================================================================
module ghost_mover #(
    parameter int MAP_W      = 28,
    parameter int MAP_H      = 31,
    parameter int X_W        = 5,
    parameter int Y_W        = 5,
    parameter bit NO_REVERSE = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           update,
    input  logic [1:0]     dirToMove,
    input  logic [X_W-1:0] intPosX,
    input  logic [Y_W-1:0] intPosY,
    input  logic           mazeRdData,
    output logic           mazeRdEn,
    output logic [X_W-1:0] mazeRdAddrX,
    output logic [Y_W-1:0] mazeRdAddrY,
    output logic [X_W-1:0] ghostPosX,
    output logic [Y_W-1:0] ghostPosY,
    output logic           canMoveU,
    output logic           canMoveR,
    output logic           canMoveD,
    output logic           canMoveL,
    output logic           movesReady,
    output logic           moveDone,
    output logic           blocked,
    output logic           updateDrop
);

    localparam logic [2:0] S_PU    = 3'd0;
    localparam logic [2:0] S_PR    = 3'd1;
    localparam logic [2:0] S_PD    = 3'd2;
    localparam logic [2:0] S_PL    = 3'd3;
    localparam logic [2:0] S_CAP   = 3'd4;
    localparam logic [2:0] S_READY = 3'd5;

    localparam logic [1:0] DIR_U = 2'd0;
    localparam logic [1:0] DIR_R = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_L = 2'd3;

    localparam logic [X_W-1:0] X_MAX = X_W'(MAP_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAP_H - 1);

    logic [2:0]     state_q, state_d;
    logic [X_W-1:0] pos_x_q, pos_x_d;
    logic [Y_W-1:0] pos_y_q, pos_y_d;
    logic           can_u_q, can_u_d;
    logic           can_r_q, can_r_d;
    logic           can_d_q, can_d_d;
    logic           can_l_q, can_l_d;
    logic [1:0]     last_dir_q, last_dir_d;
    logic           last_dir_valid_q, last_dir_valid_d;
    logic           move_done_q, move_done_d;
    logic           blocked_q, blocked_d;
    logic           update_drop_q, update_drop_d;

    logic [X_W-1:0] w_rt_x, w_lt_x;
    logic [Y_W-1:0] w_up_y, w_dn_y;
    logic           w_at_top, w_at_bot;
    logic           w_dir_open;

    // Horizontal neighbours wrap through the tunnel; vertical ones never do.
    assign w_up_y   = pos_y_q - 1'b1;
    assign w_dn_y   = pos_y_q + 1'b1;
    assign w_rt_x   = (pos_x_q == X_MAX) ? '0 : pos_x_q + 1'b1;
    assign w_lt_x   = (pos_x_q == '0) ? X_MAX : pos_x_q - 1'b1;
    assign w_at_top = (pos_y_q == '0);
    assign w_at_bot = (pos_y_q == Y_MAX);

    always_comb begin
        w_dir_open = 1'b0;
        case (dirToMove)
            DIR_U:   w_dir_open = can_u_q;
            DIR_R:   w_dir_open = can_r_q;
            DIR_D:   w_dir_open = can_d_q;
            default: w_dir_open = can_l_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_PU;
            pos_x_q          <= intPosX;
            pos_y_q          <= intPosY;
            can_u_q          <= 1'b0;
            can_r_q          <= 1'b0;
            can_d_q          <= 1'b0;
            can_l_q          <= 1'b0;
            last_dir_q       <= DIR_U;
            last_dir_valid_q <= 1'b0;
            move_done_q      <= 1'b0;
            blocked_q        <= 1'b0;
            update_drop_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            pos_x_q          <= pos_x_d;
            pos_y_q          <= pos_y_d;
            can_u_q          <= can_u_d;
            can_r_q          <= can_r_d;
            can_d_q          <= can_d_d;
            can_l_q          <= can_l_d;
            last_dir_q       <= last_dir_d;
            last_dir_valid_q <= last_dir_valid_d;
            move_done_q      <= move_done_d;
            blocked_q        <= blocked_d;
            update_drop_q    <= update_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PU:    state_d = S_PR;
            S_PR:    state_d = S_PD;
            S_PD:    state_d = S_PL;
            S_PL:    state_d = S_CAP;
            S_CAP:   state_d = S_READY;
            S_READY: if (update && w_dir_open) state_d = S_PU;
            default: state_d = S_PU;
        endcase
    end

    // Each wall bit is captured one state after its read was issued.
    always_comb begin
        pos_x_d          = pos_x_q;
        pos_y_d          = pos_y_q;
        can_u_d          = can_u_q;
        can_r_d          = can_r_q;
        can_d_d          = can_d_q;
        can_l_d          = can_l_q;
        last_dir_d       = last_dir_q;
        last_dir_valid_d = last_dir_valid_q;
        move_done_d      = 1'b0;
        blocked_d        = 1'b0;
        update_drop_d    = update && (state_q != S_READY);
        case (state_q)
            S_PR: can_u_d = ~mazeRdData & ~w_at_top;
            S_PD: can_r_d = ~mazeRdData;
            S_PL: can_d_d = ~mazeRdData & ~w_at_bot;
            S_CAP: begin
                can_l_d = ~mazeRdData;
                if (NO_REVERSE && last_dir_valid_q) begin
                    case (last_dir_q)
                        DIR_U:   can_d_d = 1'b0;
                        DIR_R:   can_l_d = 1'b0;
                        DIR_D:   can_u_d = 1'b0;
                        default: can_r_d = 1'b0;
                    endcase
                end
            end
            S_READY: begin
                if (update) begin
                    if (w_dir_open) begin
                        case (dirToMove)
                            DIR_U:   pos_y_d = w_up_y;
                            DIR_R:   pos_x_d = w_rt_x;
                            DIR_D:   pos_y_d = w_dn_y;
                            default: pos_x_d = w_lt_x;
                        endcase
                        last_dir_d       = dirToMove;
                        last_dir_valid_d = 1'b1;
                        move_done_d      = 1'b1;
                        can_u_d          = 1'b0;
                        can_r_d          = 1'b0;
                        can_d_d          = 1'b0;
                        can_l_d          = 1'b0;
                    end else begin
                        blocked_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Read strobe is gated by reset so the maze sees no access while held.
    always_comb begin
        mazeRdEn    = 1'b0;
        mazeRdAddrX = '0;
        mazeRdAddrY = '0;
        if (!reset) begin
            case (state_q)
                S_PU: if (!w_at_top) begin
                    mazeRdEn    = 1'b1;
                    mazeRdAddrX = pos_x_q;
                    mazeRdAddrY = w_up_y;
                end
                S_PR: begin
                    mazeRdEn    = 1'b1;
                    mazeRdAddrX = w_rt_x;
                    mazeRdAddrY = pos_y_q;
                end
                S_PD: if (!w_at_bot) begin
                    mazeRdEn    = 1'b1;
                    mazeRdAddrX = pos_x_q;
                    mazeRdAddrY = w_dn_y;
                end
                S_PL: begin
                    mazeRdEn    = 1'b1;
                    mazeRdAddrX = w_lt_x;
                    mazeRdAddrY = pos_y_q;
                end
                default: ;
            endcase
        end
    end

    assign ghostPosX  = pos_x_q;
    assign ghostPosY  = pos_y_q;
    assign canMoveU   = can_u_q;
    assign canMoveR   = can_r_q;
    assign canMoveD   = can_d_q;
    assign canMoveL   = can_l_q;
    assign movesReady = (state_q == S_READY);
    assign moveDone   = move_done_q;
    assign blocked    = blocked_q;
    assign updateDrop = update_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ghost_mover.sv
`default_nettype none
// ============================================================================
// Module : tb_ghost_mover
// Self-checking bench for ghost_mover with a behavioural maze ROM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ghost_mover;

    localparam int MAP_W = 28;
    localparam int MAP_H = 31;
    localparam int X_W   = 5;
    localparam int Y_W   = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           update = 1'b0;
    logic [1:0]     dirToMove = 2'd0;
    logic [X_W-1:0] intPosX = '0;
    logic [Y_W-1:0] intPosY = '0;
    logic           mazeRdData = 1'b1;
    logic           mazeRdEn;
    logic [X_W-1:0] mazeRdAddrX;
    logic [Y_W-1:0] mazeRdAddrY;
    logic [X_W-1:0] ghostPosX;
    logic [Y_W-1:0] ghostPosY;
    logic           canMoveU, canMoveR, canMoveD, canMoveL;
    logic           movesReady, moveDone, blocked, updateDrop;

    ghost_mover #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .X_W(X_W), .Y_W(Y_W), .NO_REVERSE(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .update(update), .dirToMove(dirToMove),
        .intPosX(intPosX), .intPosY(intPosY), .mazeRdData(mazeRdData),
        .mazeRdEn(mazeRdEn), .mazeRdAddrX(mazeRdAddrX), .mazeRdAddrY(mazeRdAddrY),
        .ghostPosX(ghostPosX), .ghostPosY(ghostPosY),
        .canMoveU(canMoveU), .canMoveR(canMoveR), .canMoveD(canMoveD), .canMoveL(canMoveL),
        .movesReady(movesReady), .moveDone(moveDone), .blocked(blocked), .updateDrop(updateDrop)
    );

    always #5 clk = ~clk;

    logic wall [MAP_H][MAP_W];

    always @(posedge clk) begin
        if (mazeRdEn) begin
            if (int'(mazeRdAddrY) < MAP_H && int'(mazeRdAddrX) < MAP_W)
                mazeRdData <= wall[mazeRdAddrY][mazeRdAddrX];
            else
                mazeRdData <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: read addresses encoded as x*100+y, flags as {U,R,D,L}.
    int         rd_q[$];
    logic [3:0] flag_q[$];

    int         mx, my, mlast;
    bit         mvalid;
    logic [3:0] cur_flags;

    always @(negedge clk) begin
        if (!reset && mazeRdEn) begin
            if (rd_q.size() == 0)
                check_val("rd_unexpected", int'(mazeRdAddrX) * 100 + int'(mazeRdAddrY), 32'hFFFF);
            else
                check_val("rd_addr", int'(mazeRdAddrX) * 100 + int'(mazeRdAddrY), rd_q.pop_front());
        end
    end

    task automatic start_probe();
        int  rx, lx;
        bit  fu, fr, fd, fl;
        rx = (mx + 1) % MAP_W;
        lx = (mx + MAP_W - 1) % MAP_W;
        if (my > 0) rd_q.push_back(mx * 100 + (my - 1));
        rd_q.push_back(rx * 100 + my);
        if (my < MAP_H - 1) rd_q.push_back(mx * 100 + (my + 1));
        rd_q.push_back(lx * 100 + my);
        fu = (my > 0) && !wall[my-1][mx];
        fr = !wall[my][rx];
        fd = (my < MAP_H - 1) && !wall[my+1][mx];
        fl = !wall[my][lx];
        if (mvalid) begin
            case (mlast)
                0: fd = 1'b0;
                1: fl = 1'b0;
                2: fu = 1'b0;
                default: fr = 1'b0;
            endcase
        end
        flag_q.push_back({fu, fr, fd, fl});
    endtask

    task automatic wait_ready();
        int lat;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (movesReady) begin
                lat = k;
                break;
            end
        end
        check_val("ready_latency", lat, 5);
        check_val("rd_pending", rd_q.size(), 0);
        if (flag_q.size() == 0) begin
            check_val("flags_no_expect", {canMoveU, canMoveR, canMoveD, canMoveL}, 32'hFFFF);
        end else begin
            cur_flags = flag_q.pop_front();
            check_val("flags", {canMoveU, canMoveR, canMoveD, canMoveL}, cur_flags);
        end
        check_val("pos_ready", {ghostPosX, ghostPosY}, {mx[X_W-1:0], my[Y_W-1:0]});
    endtask

    // Asserts reset immediately, checks reset outputs, then releases after a posedge.
    task automatic do_reset(input int x, input int y);
        reset   = 1'b1;
        intPosX = x[X_W-1:0];
        intPosY = y[Y_W-1:0];
        mx = x; my = y; mvalid = 1'b0;
        rd_q.delete();
        flag_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outs",
                  {ghostPosX, ghostPosY, movesReady, mazeRdEn, mazeRdAddrX, mazeRdAddrY,
                   canMoveU, canMoveR, canMoveD, canMoveL, moveDone, blocked, updateDrop},
                  {x[X_W-1:0], y[Y_W-1:0], 19'd0});
        start_probe();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_move(input int dir);
        bit open;
        open = cur_flags[3 - dir];
        update    = 1'b1;
        dirToMove = dir[1:0];
        if (open) begin
            case (dir)
                0: my = my - 1;
                1: mx = (mx + 1) % MAP_W;
                2: my = my + 1;
                default: mx = (mx + MAP_W - 1) % MAP_W;
            endcase
            mlast = dir; mvalid = 1'b1;
            start_probe();
        end
        @(posedge clk);
        #1;
        update = 1'b0;
        if (open) begin
            check_val("move_pos", {ghostPosX, ghostPosY}, {mx[X_W-1:0], my[Y_W-1:0]});
            check_val("move_pulse", {moveDone, blocked, movesReady}, 3'b100);
            wait_ready();
        end else begin
            check_val("blk_pulse", {moveDone, blocked, movesReady}, 3'b011);
            check_val("blk_pos", {ghostPosX, ghostPosY}, {mx[X_W-1:0], my[Y_W-1:0]});
            check_val("blk_flags", {canMoveU, canMoveR, canMoveD, canMoveL}, cur_flags);
            @(posedge clk);
            #1;
            check_val("blk_once", {blocked, movesReady}, 2'b01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int yy = 0; yy < MAP_H; yy++)
            for (int xx = 0; xx < MAP_W; xx++)
                wall[yy][xx] = 1'b1;
        wall[11][12] = 1'b0; wall[11][13] = 1'b0; wall[11][14] = 1'b0; wall[11][15] = 1'b0;
        wall[14][0]  = 1'b0; wall[14][1]  = 1'b0; wall[14][26] = 1'b0; wall[14][27] = 1'b0;
        wall[0][4]   = 1'b0; wall[0][6]   = 1'b0; wall[1][5]   = 1'b0;
        wall[29][5]  = 1'b0; wall[30][4]  = 1'b0; wall[30][5]  = 1'b0; wall[30][6]  = 1'b0;
        cur_flags = 4'd0;
        mlast = 0;

        // Centre tile: walls up/down, blocked request, then move right with reverse mask.
        do_reset(13, 11);
        wait_ready();
        do_move(0);
        do_move(1);

        // Drop during S_PR, then abort with reset during S_PD.
        do_reset(27, 14);
        @(posedge clk); #1;
        update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0;
        check_val("drop_pulse", {updateDrop, movesReady, moveDone}, 3'b100);
        check_val("drop_pos", {ghostPosX, ghostPosY}, {5'd27, 5'd14});
        do_reset(27, 14);
        wait_ready();
        do_move(1);

        // Top and bottom rows: edge reads suppressed and flags forced closed.
        do_reset(5, 0);
        wait_ready();
        do_move(0);
        do_reset(5, 30);
        wait_ready();
        do_move(2);
        do_move(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
